// File: rtl/updn_counter_sched.sv
// rtl/updn_counter_sched.sv - round-robin two-requester scheduler driving a 4-bit up/down counter
// Loads the winner's start value, then walks the shortest modular path to its target.
module updn_counter_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] start0,
    input  logic [3:0] target0,
    input  logic [3:0] start1,
    input  logic [3:0] target1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       err,
    output logic       busy,
    output logic       Enable,
    output logic       Load,
    output logic       UpDn,
    output logic [3:0] Data,
    input  logic [3:0] Q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       owner_q;
    logic       last_q;
    logic       dir_q;
    logic       err_q;
    logic [3:0] start_q;
    logic [3:0] target_q;
    logic [3:0] step_q;

    logic       grant_valid;
    logic       winner;
    logic [3:0] sel_start;
    logic [3:0] sel_target;
    logic [3:0] sel_diff;
    logic       count_hit;
    logic       step_max;

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        grant_valid = (state == IDLE) && (req != 2'b00);
        winner      = (req == 2'b11) ? ~last_q : req[1];
        sel_start   = winner ? start1 : start0;
        sel_target  = winner ? target1 : target0;
        sel_diff    = sel_target - sel_start;
        count_hit   = (Q == target_q);
        step_max    = (step_q == 4'd8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 4'd0;
            target_q <= 4'd0;
            step_q   <= 4'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q  <= winner;
                        last_q   <= winner;
                        start_q  <= sel_start;
                        target_q <= sel_target;
                        dir_q    <= (sel_diff <= 4'd8);
                        step_q   <= 4'd0;
                    end
                end
                COUNT: begin
                    if (count_hit) begin
                        err_q <= 1'b0;
                    end else if (step_max) begin
                        err_q <= 1'b1;
                    end else begin
                        step_q <= step_q + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = LOAD;
            LOAD:    state_nxt = COUNT;
            COUNT:   if (count_hit || step_max) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant is suppressed while reset is held so no request is accepted then.
    always_comb begin
        gnt    = 2'b00;
        done   = 2'b00;
        err    = 1'b0;
        busy   = (state != IDLE);
        Enable = 1'b0;
        Load   = 1'b0;
        UpDn   = dir_q;
        Data   = start_q;
        if (grant_valid && !rst) begin
            gnt = winner ? 2'b10 : 2'b01;
        end
        if (state == LOAD) begin
            Load = 1'b1;
        end
        if (state == COUNT) begin
            Enable = !count_hit && !step_max;
        end
        if (state == DONE) begin
            done = owner_q ? 2'b10 : 2'b01;
            err  = err_q;
        end
    end

endmodule

// File: tb/tb_updn_counter_sched.sv
// tb/tb_updn_counter_sched.sv - table-driven scoreboard bench for updn_counter_sched
module tb_updn_counter_sched;

    typedef struct {
        bit         r;
        logic [3:0] start;
        logic [3:0] target;
        bit         stuck;
        bit         updn;
        int         en;
        int         lat;
        bit         err;
        logic [3:0] q;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] start0, target0, start1, target1;
    logic [1:0] gnt, done;
    logic       err, busy, Enable, Load, UpDn;
    logic [3:0] Data, Q;

    logic [3:0] cnt = 4'd0;
    bit         stuck = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   g_cyc = 0;
    int   en_cnt = 0;
    int   n_gnt = 0;
    int   gcyc[8];
    bit   active = 1'b0;
    vec_t sb[$];
    vec_t vecs[8];

    updn_counter_sched dut (
        .clk(clk), .rst(rst), .req(req),
        .start0(start0), .target0(target0), .start1(start1), .target1(target1),
        .gnt(gnt), .done(done), .err(err), .busy(busy),
        .Enable(Enable), .Load(Load), .UpDn(UpDn), .Data(Data), .Q(Q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural counter; stuck mode pins its output at 7.
    always @(posedge clk) begin
        if (Load) cnt <= Data;
        else if (Enable) cnt <= UpDn ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign Q = stuck ? 4'd7 : cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        vec_t e;
        cyc++;
        if (rst) begin
            active = 1'b0;
        end else begin
            if (Enable) begin
                if (active) en_cnt++;
                else chk("stray_enable", Enable, 0);
            end
            if (gnt != 2'b00) begin
                if (sb.size() == 0) chk("gnt_unexpected", gnt, 0);
                else chk("gnt", {busy, gnt}, {1'b0, (sb[0].r ? 2'b10 : 2'b01)});
                if (n_gnt < 8) gcyc[n_gnt] = cyc;
                n_gnt++;
                g_cyc = cyc;
                active = 1'b1;
                en_cnt = 0;
            end
            if (active && sb.size() > 0 && cyc == g_cyc + 1)
                chk("load_phase", {Load, Enable, busy, Data}, {3'b101, sb[0].start});
            if (active && sb.size() > 0 && cyc == g_cyc + 2) begin
                chk("updn", UpDn, sb[0].updn);
                if (!sb[0].stuck) chk("q_start", Q, sb[0].start);
            end
            if (done != 2'b00 || err) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", {done, err}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_owner", done, e.r ? 2'b10 : 2'b01);
                    chk("err", err, e.err);
                    chk("done_latency", cyc - g_cyc, e.lat);
                    chk("enable_count", en_cnt, e.en);
                    chk("q_final", Q, e.q);
                end
                active = 1'b0;
            end
        end
    end

    task automatic wait_sb_empty(input string name);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk(name, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit seen;
        @(posedge clk); #1;
        stuck = v.stuck;
        if (v.r) begin start1 = v.start; target1 = v.target; end
        else begin start0 = v.start; target0 = v.target; end
        sb.push_back(v);
        req[v.r] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (gnt[v.r]) seen = 1'b1;
        end
        if (!seen) chk("gnt_timeout", 0, 1);
        @(posedge clk); #1;
        req[v.r] = 1'b0;
        start0 = 4'($urandom); target0 = 4'($urandom);
        start1 = 4'($urandom); target1 = 4'($urandom);
        wait_sb_empty("done_timeout");
        @(posedge clk); #1;
        stuck = 1'b0;
    endtask

    initial begin
        vec_t v;
        bit seen;
        vecs[0] = '{1'b0, 4'd3,  4'd6,  1'b0, 1'b1, 3, 6,  1'b0, 4'd6};
        vecs[1] = '{1'b1, 4'd1,  4'd14, 1'b0, 1'b0, 3, 6,  1'b0, 4'd14};
        vecs[2] = '{1'b0, 4'd0,  4'd8,  1'b0, 1'b1, 8, 11, 1'b0, 4'd8};
        vecs[3] = '{1'b1, 4'd15, 4'd0,  1'b0, 1'b1, 1, 4,  1'b0, 4'd0};
        vecs[4] = '{1'b0, 4'd5,  4'd5,  1'b0, 1'b1, 0, 3,  1'b0, 4'd5};
        vecs[5] = '{1'b1, 4'd9,  4'd1,  1'b0, 1'b1, 8, 11, 1'b0, 4'd1};
        vecs[6] = '{1'b0, 4'd0,  4'd3,  1'b1, 1'b1, 8, 11, 1'b1, 4'd7};
        vecs[7] = '{1'b1, 4'd4,  4'd13, 1'b0, 1'b0, 7, 10, 1'b0, 4'd13};

        // Reset held with both requesting, then tie alternation.
        rst = 1'b1; req = 2'b11;
        start0 = 4'd2; target0 = 4'd2; start1 = 4'd5; target1 = 4'd4;
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs", {gnt, done, err, busy, Enable, Load, UpDn, Data}, 0);
        end
        sb.push_back('{1'b0, 4'd2, 4'd2, 1'b0, 1'b1, 0, 3, 1'b0, 4'd2});
        sb.push_back('{1'b1, 4'd5, 4'd4, 1'b0, 1'b0, 1, 4, 1'b0, 4'd4});
        sb.push_back('{1'b0, 4'd2, 4'd2, 1'b0, 1'b1, 0, 3, 1'b0, 4'd2});
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 40 && n_gnt < 3; i++) @(negedge clk);
        if (n_gnt < 3) chk("tie_gnt_timeout", n_gnt, 3);
        @(posedge clk); #1;
        req = 2'b00;
        wait_sb_empty("tie_done_timeout");
        chk("tie_spacing_01", gcyc[1] - gcyc[0], 4);
        chk("tie_spacing_12", gcyc[2] - gcyc[1], 5);

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Reset mid-count with requester 1 pending.
        @(posedge clk); #1;
        start0 = 4'd0; target0 = 4'd8;
        sb.push_back('{1'b0, 4'd0, 4'd8, 1'b0, 1'b1, 8, 11, 1'b0, 4'd8});
        req[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (gnt[0]) seen = 1'b1;
        end
        if (!seen) chk("abort_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        req[0] = 1'b0; start1 = 4'd6; target1 = 4'd6; req[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        v = '{1'b1, 4'd6, 4'd6, 1'b0, 1'b1, 0, 3, 1'b0, 4'd6};
        sb.push_back(v);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", {Enable, busy, done, err}, 0);
        chk("abort_regrant", gnt, 2'b10);
        @(posedge clk); #1;
        req[1] = 1'b0;
        wait_sb_empty("regrant_done_timeout");

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
